// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the request unit
// Purpose: request sequencer state encoding.
// Ports: none (package).
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } reqstate_t;

endpackage

// File: rtl/req_timer.sv
// rtl/req_timer.sv - data-access watchdog counter
// Purpose: counts cycles spent waiting on a data access; flags the last allowed cycle.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   clr   in  force count to zero (wins over en)
//   en    in  increment count
//   tc    out count has reached DTIMEOUT-1
module req_timer #(
   parameter int DTIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int TW = (DTIMEOUT > 1) ? $clog2(DTIMEOUT) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TW'(DTIMEOUT - 1));

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - per-instruction memory request sequencer
// Purpose: issues instruction/data requests, holds the PC during data accesses,
//   latches halt, aborts stuck data accesses and counts stall cycles.
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   ihit, dhit         instruction / data access complete
//   cu_halt            decoded HALT
//   cu_dREN, cu_dWEN   decoded load / store
//   imemREN            instruction read request
//   dmemREN, dmemWEN   data read / write request (registered)
//   pcEn               PC update enable (combinational)
//   halt, req_err      sticky halt and sticky error
//   stall_cnt          saturating count of non-halted cycles with pcEn=0
module request_unit
   import cpu_types_pkg::*;
#(
   parameter int DTIMEOUT = 256,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             cu_halt,
   input  logic             cu_dREN,
   input  logic             cu_dWEN,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pcEn,
   output logic             halt,
   output logic             req_err,
   output logic [CNT_W-1:0] stall_cnt
);

   reqstate_t        state_q, state_d;
   logic             dmem_ren_q, dmem_ren_d;
   logic             dmem_wen_q, dmem_wen_d;
   logic             halt_q, halt_d;
   logic             req_err_q, req_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             timer_clr, timer_en, timer_tc;
   logic             pc_en_raw;
   logic             d_req;

   req_timer #(.DTIMEOUT(DTIMEOUT)) u_timer (
      .clk   (CLK),
      .rst_n (nRST),
      .clr   (timer_clr),
      .en    (timer_en),
      .tc    (timer_tc)
   );

   assign d_req = cu_dREN | cu_dWEN;

   // PC enable before reset gating; the stall counter uses this version since
   // its flop is held in reset anyway.
   always_comb begin
      pc_en_raw = 1'b0;
      case (state_q)
         FETCH:   pc_en_raw = ihit & ~cu_halt & ~d_req;
         DWAIT:   pc_en_raw = dhit;
         default: pc_en_raw = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      dmem_ren_d = dmem_ren_q;
      dmem_wen_d = dmem_wen_q;
      halt_d     = halt_q;
      req_err_d  = req_err_q;
      timer_clr  = 1'b1;
      timer_en   = 1'b0;
      case (state_q)
         FETCH: begin
            if (ihit) begin
               if (cu_halt) begin
                  state_d = HALTED;
                  halt_d  = 1'b1;
               end else if (d_req) begin
                  // A conflicting decode is treated as a store and flagged.
                  state_d    = DWAIT;
                  dmem_wen_d = cu_dWEN;
                  dmem_ren_d = cu_dREN & ~cu_dWEN;
                  if (cu_dREN & cu_dWEN) begin
                     req_err_d = 1'b1;
                  end
               end
            end
         end
         DWAIT: begin
            if (dhit) begin
               state_d    = FETCH;
               dmem_ren_d = 1'b0;
               dmem_wen_d = 1'b0;
            end else if (timer_tc) begin
               state_d    = HALTED;
               dmem_ren_d = 1'b0;
               dmem_wen_d = 1'b0;
               halt_d     = 1'b1;
               req_err_d  = 1'b1;
            end else begin
               timer_clr = 1'b0;
               timer_en  = 1'b1;
            end
         end
         default: begin
            // HALTED and the unused encoding both park here.
            state_d    = HALTED;
            dmem_ren_d = 1'b0;
            dmem_wen_d = 1'b0;
            halt_d     = 1'b1;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q != HALTED) && !pc_en_raw && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= FETCH;
         dmem_ren_q  <= 1'b0;
         dmem_wen_q  <= 1'b0;
         halt_q      <= 1'b0;
         req_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         dmem_ren_q  <= dmem_ren_d;
         dmem_wen_q  <= dmem_wen_d;
         halt_q      <= halt_d;
         req_err_q   <= req_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign imemREN   = (state_q == FETCH);
   assign dmemREN   = dmem_ren_q;
   assign dmemWEN   = dmem_wen_q;
   assign pcEn      = pc_en_raw & nRST;
   assign halt      = halt_q;
   assign req_err   = req_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule
